// File: rtl/pipeline_pkg.sv
// Shared execute-stage definitions: M-extension funct3 encodings, the
// multiply/divide FSM states and datapath sizing constants.
package pipeline_pkg;

  localparam int XLEN        = 32;
  localparam int MULDIV_ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide sharing one 64-bit accumulator, one bit per cycle.
module ex_muldiv
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int W2 = 2 * XLEN;
  localparam logic [5:0] LAST_ITER = 6'(MULDIV_ITER - 1);

  muldiv_state_e   state, state_next;
  muldiv_op_e      op, op_in;
  logic [5:0]      cnt;
  logic [W2-1:0]   acc;
  logic [XLEN-1:0] operand_b;
  logic            neg_quot, neg_rem;
  logic [XLEN-1:0] held;

  logic            accept, in_is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, op_is_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic            rem_fits;
  logic [W2-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0] quot, rem, final_result;

  assign accept = (state == IDLE) && i_start && !i_flush;

  // Operand conditioning: magnitudes plus the sign of each signed operand.
  always_comb begin
    op_in     = muldiv_op_e'(i_funct3);
    in_is_div = i_funct3[2];
    a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg     = a_signed && i_rs1_data[XLEN-1];
    b_neg     = b_signed && i_rs2_data[XLEN-1];
    a_mag     = a_neg ? -i_rs1_data : i_rs1_data;
    b_mag     = b_neg ? -i_rs2_data : i_rs2_data;
    div_zero  = in_is_div && (i_rs2_data == '0);
    div_ovf   = in_is_div && b_signed &&
                (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_data == '1);
  end

  // One iteration of each algorithm; the high half is product-high or remainder.
  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, operand_b} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[W2-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, operand_b};
    rem_fits = rem_sh >= {1'b0, operand_b};
    div_next = {(rem_fits ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                acc[XLEN-2:0], rem_fits};
  end

  always_comb begin
    prod = neg_quot ? -acc : acc;
    quot = neg_quot ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[W2-1:XLEN] : acc[W2-1:XLEN];
    op_is_div    = 1'b0;
    final_result = rem;
    case (op)
      OP_MUL:                        final_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_result = prod[W2-1:XLEN];
      OP_DIV, OP_DIVU: begin
        op_is_div    = 1'b1;
        final_result = quot;
      end
      default: begin
        op_is_div    = 1'b1;
        final_result = rem;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (div_zero || div_ovf) ? DONE : CALC;
      CALC: begin
        if (i_flush)                state_next = IDLE;
        else if (cnt == LAST_ITER)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Special cases preload the accumulator so DONE's normal selection yields them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      op        <= OP_MUL;
      cnt       <= '0;
      acc       <= '0;
      operand_b <= '0;
      neg_quot  <= 1'b0;
      neg_rem   <= 1'b0;
      held      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            op  <= op_in;
            cnt <= '0;
            if (div_zero) begin
              acc      <= {i_rs1_data, {XLEN{1'b1}}};
              neg_quot <= 1'b0;
              neg_rem  <= 1'b0;
            end else if (div_ovf) begin
              acc      <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
              neg_quot <= 1'b0;
              neg_rem  <= 1'b0;
            end else begin
              acc       <= {{XLEN{1'b0}}, a_mag};
              operand_b <= b_mag;
              neg_quot  <= a_neg ^ b_neg;
              neg_rem   <= a_neg;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            cnt <= '0;
          end else begin
            acc <= op_is_div ? div_next : mul_next;
            cnt <= (cnt == LAST_ITER) ? '0 : cnt + 6'd1;
          end
        end
        DONE: if (!i_flush) held <= final_result;
        default: ;
      endcase
    end
  end

  assign o_busy   = (state == CALC);
  assign o_stall  = accept || (state == CALC);
  assign o_valid  = (state == DONE) && !i_flush;
  assign o_result = o_valid ? final_result : held;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed results, latency, stall
// length, flush, reset and ignored-start behaviour.
module tb_ex_muldiv;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_rs1_data = '0;
  logic [31:0] i_rs2_data = '0;
  logic        i_flush = 1'b0;
  logic        o_stall, o_busy, o_valid;
  logic [31:0] o_result;

  int check_count = 0;
  int fail_count  = 0;
  logic [31:0] last_result = '0;

  ex_muldiv #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_funct3(i_funct3),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_flush(i_flush),
    .o_stall(o_stall), .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge i_clk);
    i_start    = 1'b1;
    i_funct3   = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    #1;
  endtask

  // Called in the start cycle; follows the op to its o_valid pulse.
  task automatic waitResult(input string tag, input logic [31:0] exp_val,
                            input int exp_lat);
    int lat = 0;
    int stall_cycles = 0;
    if (o_stall) stall_cycles++;
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    lat = 1;
    while (!o_valid && lat < 40) begin
      if (o_stall) stall_cycles++;
      @(negedge i_clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " result"}, o_result, exp_val);
    checkOutput({tag, " stall len"}, 32'(stall_cycles), 32'(exp_lat));
    checkOutput({tag, " stall in done"}, {31'b0, o_stall}, 32'd0);
    @(negedge i_clk);
    #1;
    checkOutput({tag, " valid pulse"}, {31'b0, o_valid}, 32'd0);
    checkOutput({tag, " held"}, o_result, exp_val);
    last_result = exp_val;
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_val,
                       input int exp_lat);
    applyStimulus(f3, a, b);
    waitResult(tag, exp_val, exp_lat);
  endtask

  initial begin
    int lat;
    int valid_seen;

    repeat (2) @(negedge i_clk);
    #1;
    checkOutput("reset valid", {31'b0, o_valid}, 32'd0);
    checkOutput("reset busy", {31'b0, o_busy}, 32'd0);
    checkOutput("reset stall", {31'b0, o_stall}, 32'd0);
    checkOutput("reset result", o_result, 32'd0);
    i_rst = 1'b0;

    runOp("MUL 7*-3",      3'b000, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    runOp("MULH min*min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    runOp("MULHU min*min", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    runOp("MULHSU min*min",3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33);
    runOp("MULHU ones",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    runOp("DIV -7/2",      3'b100, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33);
    runOp("REM -7/2",      3'b110, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33);
    runOp("DIVU 100/7",    3'b101, 32'd100,       32'd7,         32'd14,        33);
    runOp("REMU 100/7",    3'b111, 32'd100,       32'd7,         32'd2,         33);
    runOp("DIV 5/0",       3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    runOp("REM 5/0",       3'b110, 32'd5,         32'd0,         32'd5,         1);
    runOp("DIVU 5/0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    runOp("DIV ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("REM ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Flush ten cycles into a multiply.
    applyStimulus(3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      i_start = 1'b0;
    end
    i_flush = 1'b1;
    #1;
    checkOutput("flush busy before", {31'b0, o_busy}, 32'd1);
    @(negedge i_clk);
    i_flush = 1'b0;
    #1;
    checkOutput("flush busy after", {31'b0, o_busy}, 32'd0);
    checkOutput("flush stall after", {31'b0, o_stall}, 32'd0);
    checkOutput("flush result kept", o_result, last_result);
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      #1;
      if (o_valid) valid_seen++;
    end
    checkOutput("flush no valid", 32'(valid_seen), 32'd0);
    runOp("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 33);

    // Reset in the middle of CALC.
    applyStimulus(3'b000, 32'd5, 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_start = 1'b0;
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checkOutput("rst busy", {31'b0, o_busy}, 32'd0);
    checkOutput("rst stall", {31'b0, o_stall}, 32'd0);
    checkOutput("rst valid", {31'b0, o_valid}, 32'd0);
    checkOutput("rst result", o_result, 32'd0);

    // A second start during CALC must be ignored.
    applyStimulus(3'b101, 32'd100, 32'd7);
    lat = 0;
    valid_seen = 0;
    while (!o_valid && lat < 40) begin
      @(negedge i_clk);
      i_start = (lat == 4);
      i_funct3 = 3'b000;
      i_rs1_data = 32'd3;
      i_rs2_data = 32'd3;
      #1;
      lat++;
    end
    i_start = 1'b0;
    checkOutput("ignored start latency", 32'(lat), 32'd33);
    checkOutput("ignored start result", o_result, 32'd14);
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      #1;
      if (o_valid) valid_seen++;
    end
    checkOutput("ignored start no 2nd", 32'(valid_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
